div_unit: RTL and testbench

Multi-cycle 32-bit integer divider: the inverse of the single-cycle multiply path in the execute-stage ALU. It implements RISC-V DIV/DIVU/REM/REMU with a radix-2 restoring algorithm behind a start/busy/done handshake. It sits beside the ALU in EX, and the hazard unit stalls the pipeline while `busy_o` is high.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/div_unit_if.sv | 24 ++
 rtl/div_sign_fix.sv | 14 +
 rtl/div_unit.sv | 115 +++++++++++
 tb/tb_div_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared execute-stage ALU definitions: divider opcodes, divider FSM states
// and the machine word width.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface div_unit_if #(
    parameter int XLEN = alu_pkg::XLEN
);
    logic                  start_i;
    alu_pkg::div_op_t      op_i;
    logic [XLEN-1:0]       data1_i;
    logic [XLEN-1:0]       data2_i;
    logic                  busy_o;
    logic                  done_o;
    logic [XLEN-1:0]       data_o;

    // Pipeline side issuing divide requests.
    modport master (
        output start_i, op_i, data1_i, data2_i,
        input  busy_o, done_o, data_o
    );

    // Divider side.
    modport slave (
        input  start_i, op_i, data1_i, data2_i,
        output busy_o, done_o, data_o
    );
endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: used for operand magnitudes at launch
// and for quotient/remainder sign correction after the iterations.
module div_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    // Pass the value through or return its two's complement.
    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One quotient bit per cycle in CALC, sign correction in FIX, one-cycle
// done pulse in DONE. Divide-by-zero and signed overflow finish at launch.
module div_unit #(
    parameter int XLEN  = alu_pkg::XLEN,
    parameter int CNT_W = 5
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    div_unit_if.slave  bus
);
    import alu_pkg::*;

    div_state_t        state, state_next;
    div_op_t           op_q;
    logic              sign1_q, sign2_q;
    logic [XLEN-1:0]   rem_q, quo_q, dvsr_q, data_q;
    logic [CNT_W-1:0]  cnt_q;

    // Launch-side decode of the incoming request.
    logic              accept, is_signed_in, is_rem_in, neg1, neg2;
    logic              div_zero, overflow, special;
    logic [XLEN-1:0]   abs1, abs2, special_result;

    assign accept       = bus.start_i && ((state == IDLE) || (state == DONE));
    assign is_signed_in = (bus.op_i == DIV) || (bus.op_i == REM);
    assign is_rem_in    = (bus.op_i == REM) || (bus.op_i == REMU);
    assign neg1         = is_signed_in && bus.data1_i[XLEN-1];
    assign neg2         = is_signed_in && bus.data2_i[XLEN-1];
    assign div_zero     = (bus.data2_i == '0);
    assign overflow     = is_signed_in && (bus.data1_i == {1'b1, {(XLEN-1){1'b0}}})
                          && (&bus.data2_i);
    assign special      = div_zero || overflow;

    // Divide-by-zero: all ones / dividend. Overflow: dividend / zero.
    assign special_result = div_zero ? (is_rem_in ? bus.data1_i : '1)
                                     : (is_rem_in ? '0 : bus.data1_i);

    div_sign_fix #(.W(XLEN)) u_abs1 (.value(bus.data1_i), .negate(neg1), .result(abs1));
    div_sign_fix #(.W(XLEN)) u_abs2 (.value(bus.data2_i), .negate(neg2), .result(abs2));

    // One restoring step: the extra top bit keeps the trial subtract exact
    // even when the shifted remainder exceeds XLEN bits (large unsigned divisors).
    logic [XLEN:0]     rem_shift, trial;
    logic              trial_ok;

    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign trial     = rem_shift - {1'b0, dvsr_q};
    assign trial_ok  = ~trial[XLEN];

    // Sign correction: quotient negative when signs differ, remainder follows
    // the dividend. Signs were latched as zero for unsigned ops.
    logic [XLEN-1:0]   quo_fixed, rem_fixed, fix_result;

    div_sign_fix #(.W(XLEN)) u_fix_quo (.value(quo_q), .negate(sign1_q ^ sign2_q), .result(quo_fixed));
    div_sign_fix #(.W(XLEN)) u_fix_rem (.value(rem_q), .negate(sign1_q), .result(rem_fixed));

    assign fix_result = ((op_q == REM) || (op_q == REMU)) ? rem_fixed : quo_fixed;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic.
    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: if (cnt_q == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = accept ? (special ? DONE : CALC) : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration and result register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q    <= DIV;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else if (accept) begin
            op_q    <= bus.op_i;
            sign1_q <= neg1;
            sign2_q <= neg2;
            rem_q   <= '0;
            quo_q   <= abs1;
            dvsr_q  <= abs2;
            cnt_q   <= CNT_W'(XLEN - 1);
            if (special) data_q <= special_result;
        end else if (state == CALC) begin
            rem_q <= trial_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], trial_ok};
            cnt_q <= cnt_q - CNT_W'(1);
        end else if (state == FIX) begin
            data_q <= fix_result;
        end
    end

    assign bus.busy_o = (state == CALC) || (state == FIX);
    assign bus.done_o = (state == DONE);
    assign bus.data_o = data_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a timeline/arithmetic reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_div_unit;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_unit_if #(.XLEN(32)) bus ();

    div_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RISC-V division semantics in plain arithmetic.
    function automatic logic [31:0] ref_result(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REMU: return (b == 0) ? a : a % b;
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
        endcase
    endfunction

    function automatic bit ref_special(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference timeline: a normal op keeps the unit busy 33 cycles after
    // acceptance and completes in the 34th; a special case completes at once.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_data = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        int          nl;
        logic        nd;
        logic [31:0] ndata, npend;
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_data <= '0;
        end else begin
            nl = m_left; nd = 1'b0; ndata = m_data; npend = m_pend;
            if (m_left > 0) begin
                nl = m_left - 1;
                if (nl == 0) begin
                    nd    = 1'b1;
                    ndata = m_pend;
                end
            end else if (bus.start_i) begin
                if (ref_special(bus.op_i, bus.data1_i, bus.data2_i)) begin
                    nd    = 1'b1;
                    ndata = ref_result(bus.op_i, bus.data1_i, bus.data2_i);
                end else begin
                    nl    = 33;
                    npend = ref_result(bus.op_i, bus.data1_i, bus.data2_i);
                end
            end
            m_left <= nl;
            m_done <= nd;
            m_data <= ndata;
            m_pend <= npend;
        end
    end

    // Every-cycle comparison against the reference timeline.
    always @(negedge clk) begin
        check("model busy", 32'(bus.busy_o), 32'(m_left > 0));
        check("model done", 32'(bus.done_o), 32'(m_done));
        check("model data", bus.data_o, m_data);
    end

    // Called right after a falling edge; returns after the accepting edge.
    task automatic launch(input div_op_t op, input logic [31:0] a, input logic [31:0] b, output int t0);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.data1_i = a;
        bus.data2_i = b;
        @(negedge clk);
        t0          = cyc;
        bus.start_i = 1'b0;
        bus.op_i    = REMU;
        bus.data1_i = 32'hDEAD_BEEF;
        bus.data2_i = 32'h0000_0003;
    endtask

    // Bounded wait for done_o; checks result, latency and busy cycles seen.
    task automatic wait_done(input string name, input logic [31:0] exp, input int t0,
                             input int exp_lat, input int exp_busy);
        int busy_cnt = 0;
        bit seen     = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done_o) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy_o) busy_cnt++;
            @(negedge clk);
        end
        check({name, " done seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, " data"}, bus.data_o, exp);
            check({name, " latency"}, 32'(cyc - t0), 32'(exp_lat));
            check({name, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bit seen;
        bus.start_i = 1'b0;
        bus.op_i    = DIV;
        bus.data1_i = '0;
        bus.data2_i = '0;

        repeat (3) @(negedge clk);
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset done", 32'(bus.done_o), 32'd0);
        check("reset data", bus.data_o, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic unsigned divide with full timing.
        launch(DIVU, 32'd100, 32'd7, t0);
        wait_done("divu 100/7", 32'd14, t0, 33, 33);
        @(negedge clk);

        // Signed sign combinations.
        launch(DIV, 32'hFFFF_FFF9, 32'd2, t0);
        wait_done("div -7/2", 32'hFFFF_FFFD, t0, 33, 33);
        @(negedge clk);
        launch(REM, 32'hFFFF_FFF9, 32'd2, t0);
        wait_done("rem -7/2", 32'hFFFF_FFFF, t0, 33, 33);
        @(negedge clk);
        launch(DIV, 32'd7, 32'hFFFF_FFFE, t0);
        wait_done("div 7/-2", 32'hFFFF_FFFD, t0, 33, 33);
        @(negedge clk);
        launch(REM, 32'd7, 32'hFFFF_FFFE, t0);
        wait_done("rem 7/-2", 32'd1, t0, 33, 33);
        @(negedge clk);

        // Special cases finish in the first cycle without busy.
        launch(DIVU, 32'd5, 32'd0, t0);
        wait_done("divu 5/0", 32'hFFFF_FFFF, t0, 0, 0);
        @(negedge clk);
        launch(REMU, 32'd5, 32'd0, t0);
        wait_done("remu 5/0", 32'd5, t0, 0, 0);
        @(negedge clk);
        launch(DIV, 32'h8000_0000, 32'hFFFF_FFFF, t0);
        wait_done("div overflow", 32'h8000_0000, t0, 0, 0);
        @(negedge clk);
        launch(REM, 32'h8000_0000, 32'hFFFF_FFFF, t0);
        wait_done("rem overflow", 32'h0, t0, 0, 0);
        @(negedge clk);

        // Start during CALC is ignored.
        launch(DIVU, 32'd1000, 32'd10, t0);
        repeat (5) @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = DIV;
        bus.data1_i = 32'd3;
        bus.data2_i = 32'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done("ignored start", 32'd100, t0, 33, 27);

        // Back-to-back: second start issued in the DONE cycle.
        @(negedge clk);
        launch(DIVU, 32'hFFFF_FFFF, 32'd3, t0);
        wait_done("b2b first", 32'h5555_5555, t0, 33, 33);
        launch(REMU, 32'd100, 32'd7, t0);
        wait_done("b2b second", 32'd2, t0, 33, 33);
        @(negedge clk);

        // Asynchronous reset in the middle of a divide.
        launch(DIVU, 32'd100, 32'd7, t0);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 32'(bus.busy_o), 32'd0);
        check("abort done", 32'(bus.done_o), 32'd0);
        check("abort data", bus.data_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done_o) seen = 1'b1;
        end
        check("no done after abort", 32'(seen), 32'd0);
        launch(REMU, 32'hFFFF_FFFF, 32'd16, t0);
        wait_done("remu after reset", 32'd15, t0, 33, 33);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
